jpeg_ycbcr_reader: RTL and testbench

//  Read side of the YCbCr MCU buffer. It scans one 16x16 MCU held in the buffer in raster

---
 rtl/jpeg_ycbcr_reader_pkg.sv | 6 +
 rtl/jpeg_ycbcr_reader_fifo.sv | 36 +++
 rtl/jpeg_ycbcr_reader.sv | 70 +++++++
 tb/tb_jpeg_ycbcr_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jpeg_ycbcr_reader_pkg.sv
// jpeg_ycbcr_reader_pkg: shared sample width, MCU size and reader FSM states
package jpeg_ycbcr_reader_pkg;
  localparam int JPEG_SAMPLE_W = 9;
  localparam int JPEG_MCU_PIX = 256;
  typedef enum logic {ST_IDLE = 1'b0, ST_READ = 1'b1} state_t;
endpackage

// File: rtl/jpeg_ycbcr_reader_fifo.sv
// jpeg_ycbcr_fifo: register-based first-word-fallthrough sync FIFO
module jpeg_ycbcr_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wp <= r_wp + AW'(1);
      if (pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = r_mem[r_rp];
  assign empty = r_count == '0;
  assign count = r_count;
endmodule

// File: rtl/jpeg_ycbcr_reader.sv
// jpeg_ycbcr_reader: scans a 16x16 MCU from the YCbCr buffer and streams pixels out
module jpeg_ycbcr_reader
  import jpeg_ycbcr_reader_pkg::*;
#(
  parameter int DATA_W     = JPEG_SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BlockValid,
  output logic              BlockRelease,
  output logic [7:0]        DataOutAddress,
  input  logic [DATA_W-1:0] DataOutY,
  input  logic [DATA_W-1:0] DataOutCb,
  input  logic [DATA_W-1:0] DataOutCr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutY,
  output logic [DATA_W-1:0] OutCb,
  output logic [DATA_W-1:0] OutCr,
  output logic [3:0]        OutCol,
  output logic [3:0]        OutRow,
  output logic              OutLast
);
  localparam int FW = 3 * DATA_W + 9;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_ADDR = 8'(JPEG_MCU_PIX - 1);
  state_t          r_state;
  logic [7:0]      r_cnt, r_addr_d;
  logic            r_issue_d, r_guard;
  logic [CW-1:0]   w_count;
  logic            w_empty, w_issue, w_last_d;
  logic [FW-1:0]   w_dout;
  assign w_last_d       = r_addr_d == LAST_ADDR;
  assign w_issue        = r_state == ST_READ && (int'(w_count) + int'(r_issue_d)) < FIFO_DEPTH;
  assign BlockRelease   = r_issue_d & w_last_d;
  assign DataOutAddress = r_cnt;
  assign OutValid       = !w_empty;
  assign {OutY, OutCb, OutCr, OutCol, OutRow, OutLast} = w_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr_d  <= '0;
      r_issue_d <= 1'b0;
      r_guard   <= 1'b0;
    end else begin
      r_issue_d <= w_issue;
      r_addr_d  <= r_cnt;
      r_guard   <= BlockRelease;
      if (r_state == ST_IDLE && BlockValid && !r_guard && !BlockRelease) begin
        r_state <= ST_READ;
        r_cnt   <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == LAST_ADDR) r_state <= ST_IDLE;
      end
    end
  end
  jpeg_ycbcr_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_issue_d),
    .pop   (OutValid & OutReady),
    .din   ({DataOutY, DataOutCb, DataOutCr, r_addr_d[3:0], r_addr_d[7:4], w_last_d}),
    .dout  (w_dout),
    .empty (w_empty),
    .count (w_count)
  );
endmodule

// File: tb/tb_jpeg_ycbcr_reader.sv
// tb_jpeg_ycbcr_reader: scoreboard bench with a registered buffer model and random backpressure
module tb_jpeg_ycbcr_reader;
  import jpeg_ycbcr_reader_pkg::*;
  logic       clk = 0, rst = 1, BlockValid = 0, OutReady = 1;
  logic       BlockRelease, OutValid, OutLast;
  logic [7:0] DataOutAddress;
  logic [8:0] DataOutY, DataOutCb, DataOutCr, OutY, OutCb, OutCr;
  logic [3:0] OutCol, OutRow;
  typedef struct packed {
    logic [8:0] y, cb, cr;
    logic [3:0] col, row;
    logic       last;
  } pix_t;
  pix_t       sb_q[$];
  int         tests = 0, fails = 0, pops = 0, rel_cnt = 0, cyc = 0, rel_cyc = 0, last_cyc = 0;
  int         max_cnt = 0, rdy_mode = 0;
  logic [2:0] tag = 0;
  logic [7:0] rd_a = 0, prev_addr = 0;
  logic       prev_rst = 1;
  always #5 clk = ~clk;
  jpeg_ycbcr_reader dut (
    .clk(clk), .rst(rst), .BlockValid(BlockValid), .BlockRelease(BlockRelease),
    .DataOutAddress(DataOutAddress), .DataOutY(DataOutY), .DataOutCb(DataOutCb),
    .DataOutCr(DataOutCr), .OutValid(OutValid), .OutReady(OutReady), .OutY(OutY),
    .OutCb(OutCb), .OutCr(OutCr), .OutCol(OutCol), .OutRow(OutRow), .OutLast(OutLast)
  );
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_a <= DataOutAddress;
  end
  assign DataOutY  = {1'b0, rd_a};
  assign DataOutCb = {3'b0, rd_a[7:5], rd_a[3:1]};
  assign DataOutCr = {tag, rd_a[7:5], rd_a[3:1]};
  function automatic pix_t model(input int i, input logic [2:0] t);
    pix_t p;
    int   c = (i / 32) * 8 + (i % 16) / 2;
    p.y    = 9'(i);
    p.cb   = 9'(c);
    p.cr   = 9'(int'(t) * 64 + c);
    p.col  = 4'(i % 16);
    p.row  = 4'(i / 16);
    p.last = i == 255;
    return p;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    OutReady = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 99) >= 30) :
               rdy_mode == 3 ? !OutReady : 1'b0;
  end
  initial forever begin
    pix_t e;
    @(negedge clk);
    if (BlockRelease) begin
      rel_cnt++;
      rel_cyc = cyc;
    end
    if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    if (!rst && !prev_rst && DataOutAddress != prev_addr) check("addr_step", DataOutAddress, 8'(prev_addr + 8'd1));
    prev_addr = DataOutAddress;
    prev_rst  = rst;
    if (OutValid && OutReady) begin
      if (sb_q.size() == 0) check("unexpected_pixel", {OutY, OutCb, OutCr, OutCol, OutRow, OutLast}, 64'hDEAD);
      else begin
        e = sb_q.pop_front();
        check("pixel", {OutY, OutCb, OutCr, OutCol, OutRow, OutLast}, e);
      end
      pops++;
      if (OutLast) last_cyc = cyc;
    end
  end
  task automatic start_mcu();
    tick();
    BlockValid = 1;
    tag = tag + 3'd1;
    for (int i = 0; i < 256; i++) sb_q.push_back(model(i, tag));
  endtask
  task automatic wait_release();
    int r0 = rel_cnt, n = 0;
    while (rel_cnt == r0 && n < 5000) begin
      tick();
      n++;
    end
    check("release_seen", rel_cnt != r0, 1);
    BlockValid = 0;
  endtask
  task automatic run_mcu(input int mode);
    int n = 0;
    start_mcu();
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      check("latency_clk2", OutValid, 0);
      @(negedge clk);
      check("latency_clk3", OutValid, 1);
    end
    if (mode == 2) begin
      while (DataOutAddress == 0 && n < 8) begin
        tick();
        n++;
      end
      check("overlap_backlog", sb_q.size() > 256, 1);
    end
    wait_release();
  endtask
  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || OutValid) && n < 3000) begin
      tick();
      n++;
    end
    check("drained", sb_q.size(), 0);
  endtask
  initial begin
    int base, r0, a0, p0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", OutValid, 0);
    check("reset_addr", DataOutAddress, 0);
    check("reset_release", BlockRelease, 0);
    tick();
    rst = 0;
    run_mcu(1);
    drain();
    check("release_before_last", last_cyc - rel_cyc, 1);
    rdy_mode = 1;
    run_mcu(0);
    drain();
    rdy_mode = 3;
    run_mcu(0);
    run_mcu(2);
    drain();
    rdy_mode = 0;
    start_mcu();
    base = pops;
    r0 = 0;
    while (pops - base < 100 && r0 < 1000) begin
      tick();
      r0++;
    end
    r0 = rel_cnt;
    rst = 1;
    BlockValid = 0;
    tick();
    rst = 0;
    sb_q.delete();
    @(negedge clk);
    check("rst_valid", OutValid, 0);
    check("rst_addr", DataOutAddress, 0);
    check("rst_release", BlockRelease, 0);
    repeat (5) tick();
    check("rst_no_release", rel_cnt - r0, 0);
    run_mcu(0);
    drain();
    start_mcu();
    base = pops;
    a0 = 0;
    while (pops - base < 60 && a0 < 1000) begin
      tick();
      a0++;
    end
    rdy_mode = 2;
    repeat (10) tick();
    a0 = DataOutAddress;
    p0 = pops;
    repeat (40) tick();
    check("stall_addr_held", DataOutAddress, a0);
    check("stall_fifo_full", dut.u_fifo.count, 4);
    check("stall_no_pop", pops - p0, 0);
    rdy_mode = 0;
    wait_release();
    drain();
    check("release_count", rel_cnt, 6);
    check("fifo_overflow", max_cnt > 4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
